// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: req/gnt request phase, rvalid/rdata response phase.
interface load_store_unit_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage. Runs one byte/half/word load or store on a
// req/gnt/rvalid port, extends load data, pulses done (and bus_err on timeout).
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses end at once
// with bus_err and issue no request).
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      is_load,
   input  logic                      is_store,
   input  logic [2:0]                funct3,
   input  logic [31:0]               addr,
   input  logic [31:0]               store_data,
   input  logic [4:0]                rd_in,
   load_store_unit_if.master         mem,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               load_data,
   output logic [4:0]                rd_out,
   output logic                      bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   // Counter value on the last cycle allowed in REQ or WAIT.
   localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [31:0] to_cnt;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic        req_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;

   logic        start_ok;
   logic        timeout_hit;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic        misalign;

   assign mem.req   = req_q;
   assign mem.we    = we_q;
   assign mem.addr  = addr_q;
   assign mem.be    = be_q;
   assign mem.wdata = wdata_q;
   assign busy      = (state != S_IDLE);

   assign start_ok    = start && (is_load != is_store);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

   // Sign/zero extension of the selected lane; unlisted codes behave as a word.
   function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3,
                                          input logic [1:0] lane);
      logic [31:0] sh;
      logic [15:0] half;
      sh   = d >> {lane, 3'b000};
      half = lane[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
         3'b100:  extend = {24'h0, sh[7:0]};
         3'b001:  extend = {{16{half[15]}}, half};
         3'b101:  extend = {16'h0, half};
         default: extend = d;
      endcase
   endfunction

   // Byte enables, lane-replicated write data and alignment check from the launch inputs.
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = store_data;
      misalign   = 1'b0;
      case (funct3)
         3'b000, 3'b100: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{store_data[7:0]}};
         end
         3'b001, 3'b101: begin
            be_calc    = 4'b0011 << {addr[1], 1'b0};
            wdata_calc = {2{store_data[15:0]}};
            misalign   = addr[0];
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = store_data;
            misalign   = (addr[1:0] != 2'b00);
         end
      endcase
   end

   // Access sequencer: all outputs registered, done/bus_err are single-cycle pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         to_cnt    <= '0;
         f3_q      <= '0;
         lane_q    <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         done      <= 1'b0;
         bus_err   <= 1'b0;
         load_data <= '0;
         rd_out    <= '0;
      end else begin
         done    <= 1'b0;
         bus_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  f3_q      <= funct3;
                  lane_q    <= addr[1:0];
                  we_q      <= is_store;
                  addr_q    <= {addr[31:2], 2'b00};
                  be_q      <= be_calc;
                  wdata_q   <= wdata_calc;
                  rd_out    <= rd_in;
                  load_data <= '0;
                  to_cnt    <= '0;
`ifdef MISALIGN_TRAP_EN
                  if (misalign) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     bus_err <= 1'b1;
                  end else begin
                     state <= S_REQ;
                     req_q <= 1'b1;
                  end
`else
                  state <= S_REQ;
                  req_q <= 1'b1;
`endif
               end
            end
            S_REQ: begin
               if (mem.gnt) begin
                  req_q <= 1'b0;
                  if (we_q) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (mem.rvalid) begin
                     load_data <= extend(mem.rdata, f3_q, lane_q);
                     state     <= S_DONE;
                     done      <= 1'b1;
                  end else begin
                     state  <= S_WAIT;
                     to_cnt <= '0;
                  end
               end else if (timeout_hit) begin
                  req_q     <= 1'b0;
                  load_data <= '0;
                  state     <= S_DONE;
                  done      <= 1'b1;
                  bus_err   <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end
            S_WAIT: begin
               if (mem.rvalid) begin
                  load_data <= extend(mem.rdata, f3_q, lane_q);
                  state     <= S_DONE;
                  done      <= 1'b1;
               end else if (timeout_hit) begin
                  load_data <= '0;
                  state     <= S_DONE;
                  done      <= 1'b1;
                  bus_err   <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // misalign only steers the sequencer when the trap is built in.
   logic unused_ok;
   assign unused_ok = misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES=4). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        is_load = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic [4:0]  rd_in = '0;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic [4:0]  rd_out;
   logic        bus_err;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   load_store_unit_if bus ();
   assign bus.gnt    = gnt;
   assign bus.rvalid = rvalid;
   assign bus.rdata  = rdata;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .is_load    (is_load),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .rd_in      (rd_in),
      .mem        (bus.master),
      .busy       (busy),
      .done       (done),
      .load_data  (load_data),
      .rd_out     (rd_out),
      .bus_err    (bus_err)
   );

   always #5 clock = ~clock;

   task automatic launch(input logic ld, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] d, input logic [4:0] rd);
      start = 1'b1; is_load = ld; is_store = !ld;
      addr = a; funct3 = f3; store_data = d; rd_in = rd;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clock);
      n_checks++;
      if ({busy, done, bus_err, bus.req, bus.we} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, bus_err, bus.req, bus.we});
      end
      n_checks++;
      if ({load_data, rd_out, bus.addr, bus.be, bus.wdata} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h/%h want all 0", load_data, rd_out, bus.addr, bus.be, bus.wdata);
      end
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({busy, bus.req, done} !== 3'b000) begin
         n_fail++; $display("FAIL post_reset_idle: got %b want 000", {busy, bus.req, done});
      end
   endtask

   task automatic test_store(input string nm, input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] d, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      launch(1'b0, a, f3, d, 5'd0);
      @(negedge clock);
      start = 1'b0; is_store = 1'b0;
      n_checks++;
      if ({bus.req, bus.we, busy} !== 3'b111) begin
         n_fail++; $display("FAIL %s_req: got req/we/busy=%b want 111", nm, {bus.req, bus.we, busy});
      end
      n_checks++;
      if (bus.addr !== {a[31:2], 2'b00} || bus.be !== exp_be || bus.wdata !== exp_wd) begin
         n_fail++; $display("FAIL %s_bus: got addr=%h be=%b wdata=%h want addr=%h be=%b wdata=%h",
                            nm, bus.addr, bus.be, bus.wdata, {a[31:2], 2'b00}, exp_be, exp_wd);
      end
      gnt = 1'b1;
      @(negedge clock);
      gnt = 1'b0;
      n_checks++;
      if ({done, bus_err, bus.req} !== 3'b100) begin
         n_fail++; $display("FAIL %s_done: got done/err/req=%b want 100", nm, {done, bus_err, bus.req});
      end
      @(negedge clock);
      n_checks++;
      if ({done, busy} !== 2'b00) begin
         n_fail++; $display("FAIL %s_idle: got done/busy=%b want 00", nm, {done, busy});
      end
   endtask

   task automatic test_load_delayed;
      launch(1'b1, 32'h0000_0203, 3'b000, 32'h0, 5'd9);
      @(negedge clock);
      start = 1'b0; is_load = 1'b0;
      n_checks++;
      if ({bus.req, bus.we} !== 2'b10 || bus.be !== 4'b1000 || bus.addr !== 32'h200) begin
         n_fail++; $display("FAIL lb_req: got req/we=%b be=%b addr=%h want 10 1000 00000200", {bus.req, bus.we}, bus.be, bus.addr);
      end
      gnt = 1'b1;
      @(negedge clock);
      gnt = 1'b0;
      n_checks++;
      if ({bus.req, busy, done} !== 3'b010) begin
         n_fail++; $display("FAIL lb_wait: got req/busy/done=%b want 010", {bus.req, busy, done});
      end
      @(negedge clock);
      rvalid = 1'b1; rdata = 32'h80FF_FF7F;
      @(negedge clock);
      rvalid = 1'b0;
      n_checks++;
      if (done !== 1'b1 || bus_err !== 1'b0 || load_data !== 32'hFFFF_FF80 || rd_out !== 5'd9) begin
         n_fail++; $display("FAIL lb_data: got done=%b err=%b data=%h rd=%0d want 1 0 ffffff80 9", done, bus_err, load_data, rd_out);
      end
      @(negedge clock);
   endtask

   task automatic test_load_fast(input string nm, input logic [31:0] a, input logic [2:0] f3,
                                 input logic [31:0] rd_word, input logic [3:0] exp_be,
                                 input logic [31:0] exp_data);
      launch(1'b1, a, f3, 32'h0, 5'd3);
      @(negedge clock);
      start = 1'b0; is_load = 1'b0;
      n_checks++;
      if (bus.req !== 1'b1 || bus.be !== exp_be || bus.addr !== {a[31:2], 2'b00}) begin
         n_fail++; $display("FAIL %s_req: got req=%b be=%b addr=%h want 1 %b %h", nm, bus.req, bus.be, bus.addr, exp_be, {a[31:2], 2'b00});
      end
      gnt = 1'b1; rvalid = 1'b1; rdata = rd_word;
      @(negedge clock);
      gnt = 1'b0; rvalid = 1'b0;
      n_checks++;
      if (done !== 1'b1 || bus_err !== 1'b0 || load_data !== exp_data || rd_out !== 5'd3) begin
         n_fail++; $display("FAIL %s_data: got done=%b err=%b data=%h rd=%0d want 1 0 %h 3", nm, done, bus_err, load_data, rd_out, exp_data);
      end
      @(negedge clock);
   endtask

   task automatic test_timeout_req;
      launch(1'b1, 32'h0000_0600, 3'b010, 32'h0, 5'd1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clock);
         start = 1'b0; is_load = 1'b0;
         n_checks++;
         if (bus.req !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL to_req_cycle%0d: got req=%b done=%b want 1 0", i, bus.req, done);
         end
      end
      @(negedge clock);
      n_checks++;
      if ({bus.req, done, bus_err} !== 3'b011 || load_data !== 32'h0) begin
         n_fail++; $display("FAIL to_req_err: got req/done/err=%b data=%h want 011 00000000", {bus.req, done, bus_err}, load_data);
      end
      @(negedge clock);
      n_checks++;
      if ({busy, bus_err} !== 2'b00) begin
         n_fail++; $display("FAIL to_req_idle: got busy/err=%b want 00", {busy, bus_err});
      end
   endtask

   task automatic test_timeout_wait;
      launch(1'b1, 32'h0000_0604, 3'b010, 32'h0, 5'd2);
      @(negedge clock);
      start = 1'b0; is_load = 1'b0;
      gnt = 1'b1;
      @(negedge clock);
      gnt = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({busy, done} !== 2'b10) begin
         n_fail++; $display("FAIL to_wait_early: got busy/done=%b want 10", {busy, done});
      end
      @(negedge clock);
      n_checks++;
      if ({done, bus_err} !== 2'b11 || load_data !== 32'h0) begin
         n_fail++; $display("FAIL to_wait_err: got done/err=%b data=%h want 11 00000000", {done, bus_err}, load_data);
      end
      @(negedge clock);
   endtask

   task automatic test_timeout_race;
      launch(1'b0, 32'h0000_0700, 3'b010, 32'h1234_5678, 5'd0);
      repeat (3) begin
         @(negedge clock);
         start = 1'b0; is_store = 1'b0;
      end
      @(negedge clock);
      gnt = 1'b1;
      @(negedge clock);
      gnt = 1'b0;
      n_checks++;
      if ({done, bus_err, bus.req} !== 3'b100) begin
         n_fail++; $display("FAIL to_race: got done/err/req=%b want 100", {done, bus_err, bus.req});
      end
      @(negedge clock);
   endtask

   task automatic test_ignore_start;
      start = 1'b1; is_load = 1'b1; is_store = 1'b1; addr = 32'h800;
      @(negedge clock);
      n_checks++;
      if ({busy, bus.req} !== 2'b00) begin
         n_fail++; $display("FAIL ign_both: got busy/req=%b want 00", {busy, bus.req});
      end
      is_load = 1'b0; is_store = 1'b0;
      @(negedge clock);
      start = 1'b0;
      n_checks++;
      if ({busy, bus.req} !== 2'b00) begin
         n_fail++; $display("FAIL ign_neither: got busy/req=%b want 00", {busy, bus.req});
      end
   endtask

   task automatic test_start_in_wait_reset;
      launch(1'b1, 32'h0000_0400, 3'b010, 32'h0, 5'd7);
      @(negedge clock);
      start = 1'b0; is_load = 1'b0;
      gnt = 1'b1;
      @(negedge clock);
      gnt = 1'b0;
      launch(1'b0, 32'h0000_0500, 3'b010, 32'hCAFE_F00D, 5'd11);
      @(negedge clock);
      start = 1'b0; is_store = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || bus.req !== 1'b0 || bus.we !== 1'b0 || bus.addr !== 32'h400) begin
         n_fail++; $display("FAIL wait_start_ign: got busy=%b req=%b we=%b addr=%h want 1 0 0 00000400", busy, bus.req, bus.we, bus.addr);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, bus_err, bus.req} !== 4'b0 || rd_out !== 5'd0 || bus.addr !== 32'h0) begin
         n_fail++; $display("FAIL async_reset: got busy/done/err/req=%b rd=%0d addr=%h want 0000 0 00000000", {busy, done, bus_err, bus.req}, rd_out, bus.addr);
      end
      @(negedge clock);
      reset_n = 1'b1;
      rvalid = 1'b1; rdata = 32'h5555_AAAA;
      @(negedge clock);
      rvalid = 1'b0;
      n_checks++;
      if ({busy, done} !== 2'b00 || load_data !== 32'h0) begin
         n_fail++; $display("FAIL stray_rvalid: got busy/done=%b data=%h want 00 00000000", {busy, done}, load_data);
      end
   endtask

   task automatic test_misalign;
      launch(1'b1, 32'h0000_0101, 3'b010, 32'h0, 5'd4);
      @(negedge clock);
      start = 1'b0; is_load = 1'b0;
`ifdef MISALIGN_TRAP_EN
      n_checks++;
      if ({bus.req, done, bus_err} !== 3'b011 || load_data !== 32'h0) begin
         n_fail++; $display("FAIL misalign_trap: got req/done/err=%b data=%h want 011 00000000", {bus.req, done, bus_err}, load_data);
      end
      @(negedge clock);
`else
      n_checks++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h100 || bus.be !== 4'b1111) begin
         n_fail++; $display("FAIL misalign_issue: got req=%b addr=%h be=%b want 1 00000100 1111", bus.req, bus.addr, bus.be);
      end
      gnt = 1'b1; rvalid = 1'b1; rdata = 32'h1122_3344;
      @(negedge clock);
      gnt = 1'b0; rvalid = 1'b0;
      n_checks++;
      if ({done, bus_err} !== 2'b10 || load_data !== 32'h1122_3344) begin
         n_fail++; $display("FAIL misalign_data: got done/err=%b data=%h want 10 11223344", {done, bus_err}, load_data);
      end
      @(negedge clock);
`endif
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL misalign_idle: got busy=%b want 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_store("sw", 32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
      test_store("sb", 32'h0000_1001, 3'b000, 32'h1234_5678, 4'b0010, 32'h7878_7878);
      test_store("sh", 32'h0000_1002, 3'b001, 32'hAAAA_5566, 4'b1100, 32'h5566_5566);
      test_load_delayed();
      test_load_fast("lhu", 32'h0000_0202, 3'b101, 32'h8001_0000, 4'b1100, 32'h0000_8001);
      test_load_fast("lh",  32'h0000_0202, 3'b001, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
      test_load_fast("lbu", 32'h0000_0201, 3'b100, 32'h0000_9A00, 4'b0010, 32'h0000_009A);
      test_load_fast("lw7", 32'h0000_0300, 3'b111, 32'h8000_0001, 4'b1111, 32'h8000_0001);
      test_timeout_req();
      test_timeout_wait();
      test_timeout_race();
      test_ignore_start();
      test_start_in_wait_reset();
      test_misalign();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
